// File: rtl/rs255_pkg.sv
// ----------------------------------------------------------------------------
// rs255_pkg
// Shared definitions for the RS(255,247) syndrome path: code geometry, the
// frame-sequencer state type, and GF(2^8) helpers for the field generated by
// x^8 + x^4 + x^3 + x^2 + 1 (0x11d), with alpha = 0x02.
// ----------------------------------------------------------------------------
package rs255_pkg;

   localparam int unsigned RS_N    = 255;
   localparam int unsigned RS_K    = 247;
   localparam int unsigned RS_NSYM = RS_N - RS_K;   // 8 syndromes
   localparam int unsigned RS_SYMW = 8;
   localparam int unsigned CNT_W   = 8;

   // Low byte of the field polynomial, folded in when bit 7 shifts out.
   localparam logic [RS_SYMW-1:0] GF_POLY_LO = 8'h1d;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rs_state_e;

   // Shift-and-add multiply in GF(2^8).
   function automatic logic [RS_SYMW-1:0] gf_mul(input logic [RS_SYMW-1:0] a,
                                                 input logic [RS_SYMW-1:0] b);
      logic [RS_SYMW-1:0] p;
      logic [RS_SYMW-1:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < RS_SYMW; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[RS_SYMW-2:0], 1'b0} ^ (x[RS_SYMW-1] ? GF_POLY_LO : '0);
      end
      return p;
   endfunction

   // alpha^e, used to build the constant multipliers of each syndrome lane.
   function automatic logic [RS_SYMW-1:0] gf_alpha_pow(input int unsigned e);
      logic [RS_SYMW-1:0] p;
      p = 8'h01;
      for (int unsigned i = 0; i < e; i++) p = gf_mul(p, 8'h02);
      return p;
   endfunction

endpackage

// File: rtl/syndrome.sv
// ----------------------------------------------------------------------------
// syndrome
// RS(255,247) syndrome core. Evaluates the received polynomial at alpha^1 ..
// alpha^8 by Horner's rule, highest-order symbol first.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   din_val         din is valid this cycle
//   din_sop         first symbol of a codeword (reloads the accumulators)
//   din_eop         last symbol of a codeword
//   din             received symbol
//   syndrome_val    one-cycle strobe, the cycle after din_eop
//   syndrome        S1 at [7:0] .. S8 at [63:56], valid with syndrome_val
// ----------------------------------------------------------------------------
module syndrome
   import rs255_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       din_val,
   input  logic                       din_sop,
   input  logic                       din_eop,
   input  logic [RS_SYMW-1:0]         din,
   output logic                       syndrome_val,
   output logic [RS_NSYM*RS_SYMW-1:0] syndrome
);

   logic r_syn_val;

   for (genvar j = 0; j < RS_NSYM; j++) begin : g_lane
      localparam logic [RS_SYMW-1:0] ALPHA_J = gf_alpha_pow(j + 1);
      logic [RS_SYMW-1:0] r_acc;

      // NOTE: clocked state is always written with <= so every flop samples
      // the pre-edge values of its neighbours, independent of block order.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_acc <= '0;
         end else if (din_val) begin
            r_acc <= din_sop ? din : (gf_mul(r_acc, ALPHA_J) ^ din);
         end
      end

      assign syndrome[j*RS_SYMW +: RS_SYMW] = r_acc;
   end

   // Strobe follows din_eop with no valid gating; the sequencer guarantees
   // din_eop only ever accompanies din_val.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_syn_val <= 1'b0;
      else        r_syn_val <= din_eop;
   end

   assign syndrome_val = r_syn_val;

endmodule

// File: rtl/rs_syndrome_ctrl.sv
// ----------------------------------------------------------------------------
// rs_syndrome_ctrl
// Frame sequencer and result holder around the syndrome core. Frames are
// delimited only by in_sop; the symbol counter closes each frame after
// FRAME_LEN symbols. Final syndromes are held for a valid/ready consumer.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_val/in_sop/in_data  input symbol stream (no backpressure)
//   out_val/out_ready      held-result handshake
//   out_syn                S1 at [7:0] .. S8 at [63:56]
//   out_err                any held syndrome nonzero
//   short_err              pulse: open frame aborted by a new in_sop
//   stray_err              pulse: non-sop symbol outside a frame dropped
//   ovf_err                pulse: completed result dropped, holder full
// ----------------------------------------------------------------------------
module rs_syndrome_ctrl
   import rs255_pkg::*;
#(
   parameter int unsigned FRAME_LEN = RS_N   // 9..255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_val,
   input  logic                       in_sop,
   input  logic [RS_SYMW-1:0]         in_data,
   output logic                       out_val,
   input  logic                       out_ready,
   output logic [RS_NSYM*RS_SYMW-1:0] out_syn,
   output logic                       out_err,
   output logic                       short_err,
   output logic                       stray_err,
   output logic                       ovf_err
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   rs_state_e                  r_state, w_state_nxt;
   logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;

   logic                       w_din_val, w_din_sop, w_din_eop;
   logic                       w_short, w_stray;

   logic                       w_syn_val;
   logic [RS_NSYM*RS_SYMW-1:0] w_syndrome;
   logic                       w_load, w_ovf;

   logic                       r_full;
   logic [RS_NSYM*RS_SYMW-1:0] r_syn;
   logic                       r_err;
   logic                       r_short, r_stray, r_ovf;

   // -------------------------------------------------------------------------
   // Frame sequencer
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_din_val   = 1'b0;
      w_din_sop   = 1'b0;
      w_din_eop   = 1'b0;
      w_short     = 1'b0;
      w_stray     = 1'b0;

      case (r_state)
         IDLE: begin
            if (in_val) begin
               if (in_sop) begin
                  w_din_val   = 1'b1;
                  w_din_sop   = 1'b1;
                  w_cnt_nxt   = CNT_W'(1);
                  w_state_nxt = RECV;
               end else begin
                  w_stray = 1'b1;   // dropped, not forwarded
               end
            end
         end
         RECV: begin
            if (in_val) begin
               w_din_val = 1'b1;
               if (in_sop) begin
                  // Restart: the core reloads, so the old frame never ends.
                  w_din_sop = 1'b1;
                  w_short   = 1'b1;
                  w_cnt_nxt = CNT_W'(1);
               end else if (r_cnt == LAST_CNT) begin
                  w_din_eop   = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
      endcase
   end

   syndrome u_syndrome (
      .clk          (clk),
      .rst_n        (rst_n),
      .din_val      (w_din_val),
      .din_sop      (w_din_sop),
      .din_eop      (w_din_eop),
      .din          (in_data),
      .syndrome_val (w_syn_val),
      .syndrome     (w_syndrome)
   );

   // -------------------------------------------------------------------------
   // Result holder: a concurrent handshake frees the slot for the new set.
   // -------------------------------------------------------------------------
   assign w_load = w_syn_val && (!r_full || out_ready);
   assign w_ovf  = w_syn_val &&  r_full && !out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_syn  <= '0;
         r_err  <= 1'b0;
      end else if (w_load) begin
         r_full <= 1'b1;
         r_syn  <= w_syndrome;
         r_err  <= |w_syndrome;
      end else if (r_full && out_ready) begin
         r_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_short <= 1'b0;
         r_stray <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_short <= w_short;
         r_stray <= w_stray;
         r_ovf   <= w_ovf;
      end
   end

   assign out_val   = r_full;
   assign out_syn   = r_syn;
   assign out_err   = r_err;
   assign short_err = r_short;
   assign stray_err = r_stray;
   assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rs_syndrome_ctrl
// Directed scenarios plus randomized frames. The reference model keeps the
// open frame as a symbol queue and computes syndromes by direct polynomial
// evaluation with log/antilog tables; the holder and pulses are modelled as
// per-cycle events.
// ----------------------------------------------------------------------------
module tb_rs_syndrome_ctrl;

   localparam int FRAME_LEN = 255;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        in_val    = 1'b0;
   logic        in_sop    = 1'b0;
   logic [7:0]  in_data   = 8'h00;
   logic        out_ready = 1'b0;
   logic        out_val;
   logic [63:0] out_syn;
   logic        out_err;
   logic        short_err;
   logic        stray_err;
   logic        ovf_err;

   always #5 clk = ~clk;

   rs_syndrome_ctrl #(.FRAME_LEN(FRAME_LEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_val    (in_val),
      .in_sop    (in_sop),
      .in_data   (in_data),
      .out_val   (out_val),
      .out_ready (out_ready),
      .out_syn   (out_syn),
      .out_err   (out_err),
      .short_err (short_err),
      .stray_err (stray_err),
      .ovf_err   (ovf_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // ---------------------------------------------------------------- GF tables
   int gexp [0:254];
   int glog [0:255];

   task automatic init_gf();
      int x;
      gexp[0] = 1;
      glog[1] = 0;
      for (int i = 1; i < 255; i++) begin
         x = gexp[i-1] << 1;
         if (x >= 256) x = x ^ 'h11d;
         gexp[i] = x;
         glog[x] = i;
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 0 || b == 0) return 8'h00;
      return 8'(gexp[(glog[a] + glog[b]) % 255]);
   endfunction

   // ---------------------------------------------------------------- model
   logic [7:0]  m_syms[$];
   bit          m_open, m_full, m_pend;
   logic [63:0] m_held, m_pend_syn;
   logic        m_err;
   bit          e_short, e_stray, e_ovf;

   // S_j = sum_k r_{L-1-k} * alpha^(j*(L-1-k)), queue index 0 = highest order.
   function automatic logic [63:0] ref_syn();
      logic [63:0] r;
      logic [7:0]  s;
      int          len;
      r   = '0;
      len = m_syms.size();
      for (int j = 1; j <= 8; j++) begin
         s = 8'h00;
         for (int k = 0; k < len; k++)
            s = s ^ gmul(m_syms[k], 8'(gexp[(j * (len - 1 - k)) % 255]));
         r[(8*j-1) -: 8] = s;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_syms.delete();
      m_open = 0; m_full = 0; m_pend = 0;
      m_held = '0; m_pend_syn = '0; m_err = 0;
      e_short = 0; e_stray = 0; e_ovf = 0;
   endtask

   // Advances the model across one clock edge given this cycle's inputs.
   task automatic model_step(input logic v, input logic s, input logic [7:0] d,
                             input logic rdy);
      e_ovf = 0;
      if (m_pend) begin
         if (!m_full || rdy) begin
            m_held = m_pend_syn;
            m_err  = (m_pend_syn != 0);
            m_full = 1;
         end else begin
            e_ovf = 1;
         end
      end else if (m_full && rdy) begin
         m_full = 0;
      end

      m_pend = 0; e_short = 0; e_stray = 0;
      if (v) begin
         if (s) begin
            e_short = m_open;
            m_syms.delete();
            m_syms.push_back(d);
            m_open = 1;
         end else if (m_open) begin
            m_syms.push_back(d);
            if (m_syms.size() == FRAME_LEN) begin
               m_pend     = 1;
               m_pend_syn = ref_syn();
               m_open     = 0;
            end
         end else begin
            e_stray = 1;
         end
      end
   endtask

   // ---------------------------------------------------------------- driver
   int  n_short_seen, n_stray_seen, n_ovf_seen, n_val_rise;
   bit  prev_val   = 0;
   bit  rand_ready = 0;
   logic [7:0] fbuf [0:254];

   task automatic cycle(input logic v, input logic s, input logic [7:0] d);
      if (rand_ready) out_ready = ($urandom_range(0, 5) == 0);
      in_val = v; in_sop = s; in_data = d;
      model_step(v, s, d, out_ready);
      @(posedge clk); #1;
      check("out_val", 64'(out_val), 64'(m_full));
      check("out_syn", out_syn, m_held);
      check("out_err", 64'(out_err), 64'(m_err));
      check("pulses",  {61'b0, short_err, stray_err, ovf_err},
                       {61'b0, e_short, e_stray, e_ovf});
      if (short_err) n_short_seen++;
      if (stray_err) n_stray_seen++;
      if (ovf_err)   n_ovf_seen++;
      if (out_val && !prev_val) n_val_rise++;
      prev_val = out_val;
      in_val = 1'b0; in_sop = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_part(input int from, input int upto);
      for (int i = from; i <= upto; i++) cycle(1'b1, (i == 0), fbuf[i]);
   endtask

   task automatic fill(input bit rnd);
      for (int i = 0; i < FRAME_LEN; i++) fbuf[i] = rnd ? 8'($urandom) : 8'h00;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_val = 1'b0; in_sop = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check("rst_out_val", 64'(out_val),   64'd0);
      check("rst_out_syn", out_syn,        64'd0);
      check("rst_out_err", 64'(out_err),   64'd0);
      check("rst_pulses",  {61'b0, short_err, stray_err, ovf_err}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      prev_val = 0;
   endtask

   initial begin
      init_gf();
      model_reset();
      do_reset();

      // All-zero frame: result after two cycles, clean.
      fill(0);
      send_part(0, FRAME_LEN - 1);
      check("lat_before", 64'(out_val), 64'd0);
      idle(1);
      check("lat_val",  64'(out_val), 64'd1);
      check("zero_syn", out_syn,      64'd0);
      check("zero_err", 64'(out_err), 64'd0);
      handshake();
      check("hs_clear", 64'(out_val), 64'd0);

      // r0 = 1: every syndrome is 1.
      fill(0);
      fbuf[FRAME_LEN-1] = 8'h01;
      send_part(0, FRAME_LEN - 1);
      idle(1);
      check("r0_syn", out_syn,      64'h0101010101010101);
      check("r0_err", 64'(out_err), 64'd1);
      handshake();

      // r1 = 1: S_j = alpha^j.
      fill(0);
      fbuf[FRAME_LEN-2] = 8'h01;
      send_part(0, FRAME_LEN - 1);
      idle(1);
      check("r1_syn", out_syn,      64'h1d80402010080402);
      check("r1_err", 64'(out_err), 64'd1);
      handshake();

      // Early sop at symbol 100, then a full frame.
      n_short_seen = 0; n_val_rise = 0;
      fill(1);
      send_part(0, 98);
      fill(1);
      send_part(0, FRAME_LEN - 1);
      idle(3);
      check("short_cnt",  64'(n_short_seen), 64'd1);
      check("short_rslt", 64'(n_val_rise),   64'd1);
      handshake();

      // Back-to-back frames with no ready: one overflow, first result held.
      n_ovf_seen = 0;
      fill(1);
      send_part(0, FRAME_LEN - 1);
      fill(1);
      send_part(0, FRAME_LEN - 1);
      idle(3);
      check("ovf_cnt",  64'(n_ovf_seen), 64'd1);
      check("ovf_held", 64'(out_val),    64'd1);
      handshake();
      idle(1);
      check("ovf_drain", 64'(out_val), 64'd0);

      // Strays in IDLE, then reset mid-frame, then a clean frame.
      n_stray_seen = 0;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom));
      check("stray_cnt", 64'(n_stray_seen), 64'd5);
      fill(1);
      send_part(0, 49);
      do_reset();
      fill(1);
      send_part(0, FRAME_LEN - 1);
      idle(1);
      check("post_rst_val", 64'(out_val), 64'd1);
      handshake();

      // Randomized frames, aborts, strays, gaps and ready.
      rand_ready = 1;
      for (int f = 0; f < 15; f++) begin
         fill(1);
         if ($urandom_range(0, 3) == 0) send_part(0, int'($urandom_range(1, 200)));
         fill(1);
         send_part(0, FRAME_LEN - 1);
         for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
            if ($urandom_range(0, 4) == 0) cycle(1'b1, 1'b0, 8'($urandom));
            else                           cycle(1'b0, 1'b0, 8'h00);
         end
      end
      idle(20);
      rand_ready = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
